// File: rtl/wb_pkg.sv
// Shared definitions for the write-back arbiter: widths, requester indices
// and the request payload record.
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int RIDX_W = 5;
  localparam int NREG   = 32;

  localparam int REQ_ALU    = 0;
  localparam int REQ_LOAD   = 1;
  localparam int REQ_MULDIV = 2;

  typedef struct packed {
    logic [RIDX_W-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: scans requests starting at ptr, wrapping around,
// and returns the first asserted one as a one-hot grant plus its index.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found;
  int   k;

  // Priority scan from ptr upward with wraparound; first request wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int off = 0; off < N; off++) begin
      k = int'(ptr) + off;
      if (k >= N) k = k - N;
      if (!found && req[k]) begin
        gnt[k] = 1'b1;
        idx    = IW'(k);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: picks one requester per cycle round-robin, registers
// the winner onto the register-file write port (1-cycle latency), and keeps
// a pending-write scoreboard for x1..x31.
module wb_arbiter #(
  parameter  int NREQ = 3,
  parameter  int XLEN = wb_pkg::XLEN
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NREQ-1:0]                         req_valid,
  input  logic [NREQ-1:0][wb_pkg::RIDX_W-1:0]     req_rd,
  input  logic [NREQ-1:0][XLEN-1:0]               req_data,
  output logic [NREQ-1:0]                         req_ready,
  input  logic                                    wb_hold,
  input  logic                                    iss_valid,
  input  logic [wb_pkg::RIDX_W-1:0]               iss_rd,
  output logic                                    rf_we,
  output logic [wb_pkg::RIDX_W-1:0]               rf_rd,
  output logic [XLEN-1:0]                         rf_data,
  output logic [wb_pkg::NREG-1:0]                 busy
);

  import wb_pkg::*;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   gnt;
  logic [IW-1:0]     win_idx;
  logic              xfer;
  logic [RIDX_W-1:0] win_rd;
  logic [XLEN-1:0]   win_data;

  logic              rf_we_q,   rf_we_d;
  logic [RIDX_W-1:0] rf_rd_q,   rf_rd_d;
  logic [XLEN-1:0]   rf_data_q, rf_data_d;
  logic [NREG-1:0]   busy_q,    busy_d;

  // Requests are masked during reset and hold so no grant can leak out;
  // only valid/hold/pointer feed the selector, never rd or data.
  assign elig = (rst_n && !wb_hold) ? req_valid : '0;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req (elig),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (win_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign win_rd    = req_rd[win_idx];
  assign win_data  = req_data[win_idx];

  // Pointer moves past the winner only when a transfer completes.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
    end
  end

  // Output register: capture the winner; writes to x0 are swallowed.
  always_comb begin
    rf_we_d   = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (xfer) begin
      rf_we_d   = (win_rd != '0);
      rf_rd_d   = win_rd;
      rf_data_d = win_data;
    end
  end

  // Scoreboard next state: clear first, then set, so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (xfer && (win_rd != '0)) busy_d[win_rd] = 1'b0;
    if (iss_valid && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // State registers; reset also discards any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      rf_we_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
      busy_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      rf_we_q   <= rf_we_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      busy_q    <= busy_d;
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_rd   = rf_rd_q;
  assign rf_data = rf_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a vector table, directed corner sequences, and a
// randomized run against a behavioural model of the arbiter rules.
module tb_wb_arbiter;

  localparam int NREQ = 3;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0][4:0]  req_rd;
  logic [NREQ-1:0][31:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wb_hold;
  logic                  iss_valid;
  logic [4:0]            iss_rd;
  logic                  rf_we;
  logic [4:0]            rf_rd;
  logic [31:0]           rf_data;
  logic [31:0]           busy;

  int total = 0;
  int bad   = 0;

  wb_arbiter #(.NREQ(NREQ), .XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wb_hold   (wb_hold),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_data   (rf_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic        hold;
    logic [2:0]  ready;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    wb_hold   = 1'b0;
    iss_valid = 1'b0;
    iss_rd    = '0;
  endtask

  // Reset for two edges; returns at edge+1 with rst_n just released.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // Behavioural model state for the random run.
  int          m_last;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [31:0] m_busy;
  logic [2:0]  pend;
  int          wait_cnt[NREQ];

  function automatic int model_grant(input logic [2:0] v, input logic h, input int last);
    model_grant = -1;
    if (!h) begin
      for (int s = 1; s <= NREQ; s++) begin
        if (model_grant < 0 && v[(last + s) % NREQ]) model_grant = (last + s) % NREQ;
      end
    end
  endfunction

  initial begin
    rst_n = 1'b0;
    clear_inputs();

    // Reset state, with requests present to show ready stays low.
    req_valid = 3'b111;
    #3;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_rd", 64'(rf_rd), 64'd0);
    chk("rst_data", 64'(rf_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // ---------------- table-driven vectors ----------------
    tbl[0]  = '{3'b111, 1'b0, 3'b001, 1'b0, 5'd0, 32'h0};
    tbl[1]  = '{3'b111, 1'b0, 3'b010, 1'b1, 5'd1, 32'h100};
    tbl[2]  = '{3'b111, 1'b0, 3'b100, 1'b1, 5'd2, 32'h101};
    tbl[3]  = '{3'b111, 1'b0, 3'b001, 1'b1, 5'd3, 32'h102};
    tbl[4]  = '{3'b000, 1'b0, 3'b000, 1'b1, 5'd1, 32'h100};
    tbl[5]  = '{3'b101, 1'b1, 3'b000, 1'b0, 5'd0, 32'h0};
    tbl[6]  = '{3'b101, 1'b0, 3'b100, 1'b0, 5'd0, 32'h0};
    tbl[7]  = '{3'b011, 1'b0, 3'b001, 1'b1, 5'd3, 32'h102};
    tbl[8]  = '{3'b110, 1'b0, 3'b010, 1'b1, 5'd1, 32'h100};
    tbl[9]  = '{3'b001, 1'b0, 3'b001, 1'b1, 5'd2, 32'h101};
    tbl[10] = '{3'b000, 1'b0, 3'b000, 1'b1, 5'd1, 32'h100};

    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_rd[i]   = 5'(i + 1);
      req_data[i] = 32'h100 + 32'(i);
    end
    for (int r = 0; r < 11; r++) begin
      req_valid = tbl[r].valid;
      wb_hold   = tbl[r].hold;
      #4;
      chk($sformatf("tbl%0d_ready", r), 64'(req_ready), 64'(tbl[r].ready));
      chk($sformatf("tbl%0d_we", r), 64'(rf_we), 64'(tbl[r].we));
      if (tbl[r].we) begin
        chk($sformatf("tbl%0d_rd", r), 64'(rf_rd), 64'(tbl[r].rd));
        chk($sformatf("tbl%0d_data", r), 64'(rf_data), 64'(tbl[r].data));
      end
      next_cycle();
    end

    // ---------------- hold for 3 cycles ----------------
    do_reset();
    req_valid   = 3'b010;
    req_rd[1]   = 5'd5;
    req_data[1] = 32'hDEADBEEF;
    wb_hold     = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #4;
      chk("hold_ready", 64'(req_ready), 64'd0);
      chk("hold_we", 64'(rf_we), 64'd0);
      next_cycle();
    end
    wb_hold = 1'b0;
    #4;
    chk("hold_drop_ready", 64'(req_ready), 64'b010);
    next_cycle();
    req_valid = '0;
    #4;
    chk("hold_out_we", 64'(rf_we), 64'd1);
    chk("hold_out_rd", 64'(rf_rd), 64'd5);
    chk("hold_out_data", 64'(rf_data), 64'hDEADBEEF);
    next_cycle();
    #4;
    chk("idle_we", 64'(rf_we), 64'd0);
    chk("idle_rd_held", 64'(rf_rd), 64'd5);
    chk("idle_data_held", 64'(rf_data), 64'hDEADBEEF);
    next_cycle();

    // ---------------- transfer to x0 ----------------
    req_valid   = 3'b001;
    req_rd[0]   = 5'd0;
    req_data[0] = 32'h12345678;
    iss_valid   = 1'b1;
    iss_rd      = 5'd3;
    #4;
    chk("x0_ready", 64'(req_ready), 64'b001);
    next_cycle();
    req_valid = '0;
    iss_valid = 1'b0;
    #4;
    chk("x0_we", 64'(rf_we), 64'd0);
    chk("x0_busy", 64'(busy), 64'h8);

    // ---------------- scoreboard set / clear / collision ----------------
    next_cycle();
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    next_cycle();
    iss_valid   = 1'b0;
    req_valid   = 3'b001;
    req_rd[0]   = 5'd7;
    req_data[0] = 32'h77;
    #4;
    chk("sb_set", 64'(busy), 64'h88);
    chk("sb_clr_ready", 64'(req_ready), 64'b001);
    next_cycle();
    iss_valid = 1'b1;
    #4;
    chk("sb_clr", 64'(busy), 64'h08);
    chk("sb_clr_we", 64'(rf_we), 64'd1);
    chk("sb_clr_rd", 64'(rf_rd), 64'd7);
    chk("sb_both_ready", 64'(req_ready), 64'b001);
    next_cycle();
    iss_valid = 1'b0;
    req_valid = '0;
    #4;
    chk("sb_set_wins", 64'(busy), 64'h88);

    // ---------------- reset right after a transfer ----------------
    next_cycle();
    req_valid   = 3'b001;
    req_rd[0]   = 5'd9;
    req_data[0] = 32'h99;
    #4;
    chk("rst9_ready", 64'(req_ready), 64'b001);
    next_cycle();
    rst_n     = 1'b0;
    req_valid = 3'b111;
    #4;
    chk("rst9_we", 64'(rf_we), 64'd0);
    chk("rst9_busy", 64'(busy), 64'd0);
    chk("rst9_ready_low", 64'(req_ready), 64'd0);
    next_cycle();
    rst_n     = 1'b1;
    req_valid = '0;
    #4;
    chk("rst9_we_after", 64'(rf_we), 64'd0);
    next_cycle();
    req_valid = 3'b111;
    #4;
    chk("rst9_ptr0", 64'(req_ready), 64'b001);
    chk("rst9_we_after2", 64'(rf_we), 64'd0);
    next_cycle();

    // ---------------- randomized run against the model ----------------
    do_reset();
    m_last = NREQ - 1;
    m_we   = 1'b0;
    m_rd   = '0;
    m_data = '0;
    m_busy = '0;
    pend   = '0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;

    for (int cyc = 0; cyc < 10000; cyc++) begin
      int g;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom % 3 == 0)) pend[i] = 1'b1;
        req_rd[i]   = 5'($urandom);
        req_data[i] = $urandom;
      end
      req_valid = pend;
      wb_hold   = ($urandom % 6 == 0);
      iss_valid = $urandom % 2;
      iss_rd    = 5'($urandom);
      #4;
      g = model_grant(req_valid, wb_hold, m_last);
      chk("rnd_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
      chk("rnd_we", 64'(rf_we), 64'(m_we));
      if (m_we) begin
        chk("rnd_rd", 64'(rf_rd), 64'(m_rd));
        chk("rnd_data", 64'(rf_data), 64'(m_data));
      end
      chk("rnd_busy", 64'(busy), 64'(m_busy));
      if (g >= 0) chk("rnd_fair", 64'(wait_cnt[g] < NREQ), 64'd1);
      @(posedge clk);
      if (g >= 0) begin
        for (int i = 0; i < NREQ; i++) begin
          if (i == g) wait_cnt[i] = 0;
          else if (pend[i]) wait_cnt[i]++;
        end
        pend[g] = 1'b0;
        m_last  = g;
        m_we    = (req_rd[g] != 5'd0);
        m_rd    = req_rd[g];
        m_data  = req_data[g];
        if (req_rd[g] != 5'd0) m_busy[req_rd[g]] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (iss_valid && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
